// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and default width.
package serial_adder_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/serial_adder_fa_cell.sv
// fa_cell: single-bit combinational full adder used as the serial adder's bit slice.
// Ports:
//   a_i, b_i, cin_i : operand bits and carry-in
//   s_c_o           : sum bit (combinational)
//   cout_c_o        : carry-out (combinational)
module fa_cell (
  input  logic a_i,
  input  logic b_i,
  input  logic cin_i,
  output logic s_c_o,
  output logic cout_c_o
);

  assign s_c_o    = a_i ^ b_i ^ cin_i;
  assign cout_c_o = (a_i & b_i) | (a_i & cin_i) | (b_i & cin_i);

endmodule

// File: rtl/serial_adder.sv
// serial_adder: bit-serial adder, one bit per clock LSB first, through one full-adder
// cell and a carry flip-flop. Operands arrive on a valid/ready handshake and the
// registered result leaves on a second valid/ready handshake.
// Optional feature: define SERIAL_ADDER_SUB_EN to add the sub port (A - B mode).
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : operand handshake (ready only in IDLE)
//   a, b, c             : WIDTH-bit operands and carry-in
//   sub                 : subtract mode, sampled at accept (SERIAL_ADDER_SUB_EN only)
//   out_valid/out_ready : result handshake (valid only in DONE)
//   sum, carry          : registered result and carry-out (in subtract mode, 1 = no borrow)
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_e            state_q,     state_d;
  logic [CNT_W-1:0]  cnt_q,       cnt_d;
  logic [WIDTH-1:0]  a_sr_q,      a_sr_d;
  logic [WIDTH-1:0]  b_sr_q,      b_sr_d;
  logic [WIDTH-1:0]  sum_sr_q,    sum_sr_d;
  logic              cy_q,        cy_d;
  logic              in_ready_q,  in_ready_d;
  logic              out_valid_q, out_valid_d;

  logic              fa_s;
  logic              fa_cout;

  // Per-bit slice: current LSBs plus the carry flop.
  fa_cell u_fa (
    .a_i      (a_sr_q[0]),
    .b_i      (b_sr_q[0]),
    .cin_i    (cy_q),
    .s_c_o    (fa_s),
    .cout_c_o (fa_cout)
  );

  // Next-state and datapath update.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    a_sr_d      = a_sr_q;
    b_sr_d      = b_sr_q;
    sum_sr_d    = sum_sr_q;
    cy_d        = cy_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          state_d    = RUN;
          cnt_d      = '0;
          a_sr_d     = a;
          b_sr_d     = b;
          cy_d       = c;
          sum_sr_d   = '0;
          in_ready_d = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
          // A - B computed as A + ~B + 1.
          if (sub) begin
            b_sr_d = ~b;
            cy_d   = 1'b1;
          end
`endif
        end
      end

      RUN: begin
        cy_d     = fa_cout;
        a_sr_d   = a_sr_q >> 1;
        b_sr_d   = b_sr_q >> 1;
        sum_sr_d = {fa_s, sum_sr_q[WIDTH-1:1]};
        // Counter holds on the last bit so it never wraps inside a word.
        if (cnt_q == LAST_BIT) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      DONE: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      end

      default: begin
        state_d     = IDLE;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      a_sr_q      <= '0;
      b_sr_q      <= '0;
      sum_sr_q    <= '0;
      cy_q        <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      a_sr_q      <= a_sr_d;
      b_sr_q      <= b_sr_d;
      sum_sr_q    <= sum_sr_d;
      cy_q        <= cy_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sum       = sum_sr_q;
  assign carry     = cy_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed cases, backpressure, async reset,
// optional subtract mode, random words at WIDTH=8 and a back-to-back sweep at WIDTH=4.
module tb_serial_adder;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // WIDTH=8 instance
  logic       in_valid8, in_ready8, out_valid8, out_ready8, c8, sub8, carry8;
  logic [7:0] a8, b8, sum8;
  // WIDTH=4 instance
  logic       in_valid4, in_ready4, out_valid4, out_ready4, c4, sub4, carry4;
  logic [3:0] a4, b4, sum4;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .c(c8),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub8),
`endif
    .out_valid(out_valid8), .out_ready(out_ready8),
    .sum(sum8), .carry(carry8)
  );

  serial_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid4), .in_ready(in_ready4),
    .a(a4), .b(b4), .c(c4),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub4),
`endif
    .out_valid(out_valid4), .out_ready(out_ready4),
    .sum(sum4), .carry(carry4)
  );

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain arithmetic on w-bit operands; returns {carry, sum} in the low w+1 bits.
  function automatic logic [31:0] ref_result(input int unsigned w, input logic [31:0] x,
                                             input logic [31:0] y, input logic cin,
                                             input logic sb);
    logic [31:0] mask;
    mask = (32'd1 << w) - 32'd1;
    if (sb) return (x & mask) + (~y & mask) + 32'd1;
    return (x & mask) + (y & mask) + {31'd0, cin};
  endfunction

  // Called at the negedge right after an accept edge; counts edges until out_valid.
  task automatic wait_result8(input string tag, input logic [31:0] r);
    int lat;
    lat = 0;
    while (!out_valid8 && lat < 50) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, lat, 8);
    check({tag, "_sum"},   {24'd0, sum8},  {24'd0, r[7:0]});
    check({tag, "_carry"}, {31'd0, carry8}, {31'd0, r[8]});
  endtask

  task automatic run_word8(input string tag, input logic [7:0] x, input logic [7:0] y,
                           input logic cin, input logic sb);
    logic [31:0] r;
    r = ref_result(8, x, y, cin, sb);
    @(negedge clk);
    check({tag, "_in_ready"}, {31'd0, in_ready8}, 32'd1);
    in_valid8 = 1'b1; a8 = x; b8 = y; c8 = cin; sub8 = sb;
    @(posedge clk);
    @(negedge clk);
    in_valid8 = 1'b0;
    wait_result8(tag, r);
    @(posedge clk);
    @(negedge clk);
    check({tag, "_idle_ready"}, {31'd0, in_ready8}, 32'd1);
  endtask

  logic [31:0] r;
  logic [31:0] q[$];
  logic        sb;
  int          idx, cyc, last, n_acc, n_res;
  logic        adv;

  initial begin
    rst_n = 1'b0;
    in_valid8 = 0; a8 = '0; b8 = '0; c8 = 0; sub8 = 0; out_ready8 = 1;
    in_valid4 = 0; a4 = '0; b4 = '0; c4 = 0; sub4 = 0; out_ready4 = 1;
    #12;
    check("rst_in_ready",  {31'd0, in_ready8},  32'd1);
    check("rst_out_valid", {31'd0, out_valid8}, 32'd0);
    check("rst_sum",       {24'd0, sum8},       32'd0);
    check("rst_carry",     {31'd0, carry8},     32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed adds
    run_word8("zero",  8'h00, 8'h00, 1'b0, 1'b0);
    run_word8("ff_01", 8'hFF, 8'h01, 1'b0, 1'b0);
    run_word8("a5_5a", 8'hA5, 8'h5A, 1'b1, 1'b0);

    // Backpressure: result held, stale in_valid ignored, next word accepted after release
    out_ready8 = 1'b0;
    r = ref_result(8, 32'h3C, 32'h99, 1'b0, 1'b0);
    @(negedge clk);
    in_valid8 = 1; a8 = 8'h3C; b8 = 8'h99; c8 = 0; sub8 = 0;
    @(posedge clk);
    @(negedge clk);
    in_valid8 = 1; a8 = 8'h11; b8 = 8'h22; c8 = 1;
    wait_result8("bp", r);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("bp_hold_sum",   {24'd0, sum8},       {24'd0, r[7:0]});
      check("bp_hold_carry", {31'd0, carry8},     {31'd0, r[8]});
      check("bp_hold_valid", {31'd0, out_valid8}, 32'd1);
      check("bp_in_ready",   {31'd0, in_ready8},  32'd0);
    end
    out_ready8 = 1'b1;
    r = ref_result(8, 32'h11, 32'h22, 1'b1, 1'b0);
    @(posedge clk);
    @(negedge clk);
    check("bp_release_ready", {31'd0, in_ready8},  32'd1);
    check("bp_release_valid", {31'd0, out_valid8}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    in_valid8 = 0;
    check("bp_next_accepted", {31'd0, in_ready8}, 32'd0);
    wait_result8("bp_next", r);
    @(posedge clk);

    // Asynchronous reset mid-RUN
    @(negedge clk);
    in_valid8 = 1; a8 = 8'h3C; b8 = 8'h0F; c8 = 1;
    @(posedge clk);
    @(negedge clk);
    in_valid8 = 0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_in_ready",  {31'd0, in_ready8},  32'd1);
    check("midrst_out_valid", {31'd0, out_valid8}, 32'd0);
    check("midrst_sum",       {24'd0, sum8},       32'd0);
    check("midrst_carry",     {31'd0, carry8},     32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_word8("post_rst", 8'h12, 8'h34, 1'b0, 1'b0);

`ifdef SERIAL_ADDER_SUB_EN
    run_word8("sub_5_7", 8'h05, 8'h07, 1'b0, 1'b1);
    run_word8("sub_7_5", 8'h07, 8'h05, 1'b1, 1'b1);
`endif

    // Random words
    for (int i = 0; i < 16; i++) begin
      sb = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
      sb = 1'($urandom_range(1));
`endif
      run_word8("rand", 8'($urandom), 8'($urandom), 1'($urandom_range(1)), sb);
    end

    // Back-to-back sweep at WIDTH=4, in_valid held high
    idx = 0; cyc = 0; last = 0; n_acc = 0; n_res = 0;
    @(negedge clk);
    in_valid4 = 1; a4 = 4'(idx & 7); b4 = 4'((idx >> 3) & 7); c4 = 1'((idx >> 6) & 1);
    while (n_res < 128 && cyc < 2000) begin
      if (out_valid4) begin
        if (q.size() == 0) check("b2b_spurious_result", 32'd1, 32'd0);
        else begin
          r = q.pop_front();
          check("b2b_sum",   {28'd0, sum4},   {28'd0, r[3:0]});
          check("b2b_carry", {31'd0, carry4}, {31'd0, r[4]});
        end
        n_res++;
      end
      adv = 1'b0;
      if (in_ready4 && in_valid4) begin
        q.push_back(ref_result(4, {28'd0, a4}, {28'd0, b4}, c4, 1'b0));
        if (n_acc > 0) check("b2b_interval", cyc - last, 6);
        last = cyc;
        n_acc++;
        adv = 1'b1;
      end
      @(posedge clk);
      @(negedge clk);
      cyc++;
      if (adv) begin
        idx++;
        if (idx < 128) begin
          a4 = 4'(idx & 7); b4 = 4'((idx >> 3) & 7); c4 = 1'((idx >> 6) & 1);
        end else begin
          in_valid4 = 0;
        end
      end
    end
    check("b2b_timeout",  {31'd0, 1'(cyc >= 2000)}, 32'd0);
    check("b2b_accepts",  n_acc, 128);
    check("b2b_results",  n_res, 128);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
